// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem read handshake,
// IF/ID output register with a one-entry skid buffer, and redirect flushing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  typedef enum logic {ST_REQ, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        drop_q, drop_d;

  logic        deliver;
  logic        advance;

  // Requests stop while the skid entry is full, so a response can always land.
  always_comb begin
    imem_req  = rst_n && (state_q == ST_REQ) && !skid_valid_q && !redirect_valid;
    imem_addr = pc_q & 32'hFFFF_FFFC;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    drop_d       = drop_q;

    deliver = (state_q == ST_WAIT) && imem_rvalid && !drop_q && !redirect_valid;
    advance = !if_valid_q || id_ready;

    if (redirect_valid) begin
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
      skid_valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end else begin
          drop_d  = 1'b1;
        end
      end
    end else begin
      if (state_q == ST_REQ) begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end else if (imem_rvalid) begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end

      if (advance) begin
        if (skid_valid_q) begin
          if_valid_d   = 1'b1;
          if_pc_d      = skid_pc_q;
          if_instr_d   = skid_instr_q;
          skid_valid_d = 1'b0;
        end else if (deliver) begin
          if_valid_d = 1'b1;
          if_pc_d    = req_pc_q;
          if_instr_d = imem_rdata;
        end else begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end

      // A response that could not go straight into IF/ID parks in the skid entry.
      if (deliver && !(advance && !skid_valid_q)) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      // NOTE: skid payload is reset too; it is one entry wide, so a known value costs little and keeps X out of IF/ID.
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      drop_q       <= drop_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[6:0];

endmodule
